// File: rtl/miriscv_mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package miriscv_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_e;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS);

endpackage

// File: rtl/miriscv_mdu_div.sv
// Iterative unsigned 32/32 restoring divider, one quotient bit per cycle.
// The start cycle performs the first step; done_o flags the cycle computing the last bit.
module miriscv_mdu_div
  import miriscv_mdu_pkg::*;
(
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        done_o
);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;

  logic [31:0] rem_in, quo_in, dsr_in;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] step_rem, step_quo;

  // Partial remainder stays below the divisor, so the difference fits in 32 bits.
  always_comb begin
    rem_in   = start_i ? 32'd0      : rem_q;
    quo_in   = start_i ? dividend_i : quo_q;
    dsr_in   = start_i ? divisor_i  : dsr_q;
    shifted  = {rem_in, quo_in[31]};
    ge       = shifted >= {1'b0, dsr_in};
    step_rem = ge ? (shifted[31:0] - dsr_in) : shifted[31:0];
    step_quo = {quo_in[30:0], ge};
  end

  assign done_o      = busy_q && (cnt_q == CNT_W'(DIV_ITERS - 1));
  assign quotient_o  = step_quo;
  assign remainder_o = step_rem;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    if (kill_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(1);
      rem_d  = step_rem;
      quo_d  = step_quo;
      dsr_d  = divisor_i;
    end else if (busy_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = done_o ? '0 : cnt_q + CNT_W'(1);
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
    end
  end

endmodule

// File: rtl/miriscv_mdu.sv
// RV32M multiply/divide unit: MUL 2 cycles, DIV 33 cycles (2 for divide-by-zero/overflow).
// Stalls the pipeline while busy; kill aborts immediately, keep suppresses a restart.
module miriscv_mdu
  import miriscv_mdu_pkg::*;
(
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        mdu_req_i,
  input  logic [31:0] mdu_port_a_i,
  input  logic [31:0] mdu_port_b_i,
  input  logic [2:0]  mdu_op_i,
  input  logic        mdu_kill_i,
  input  logic        mdu_keep_i,
  output logic        mdu_stall_req_o,
  output logic [31:0] mdu_result_o
);

  mdu_state_e  state_q, state_d;
  mdu_op_e     op_q;
  logic [31:0] a_q, b_q, result_q, result_d;
  logic        div_first_q;
  logic        start_en, stall;

  logic        signed_div, a_neg, b_neg, div_zero, div_ovf, special, div_start, div_done;
  logic [31:0] a_abs, b_abs, div_quo, div_rem, quo_fin, rem_fin, quo_sp, rem_sp;
  logic        mul_a_sx, mul_b_sx;
  logic signed [63:0] mul_a, mul_b, mul_p;

  // 33x33 signed product; its low 64 bits are exact for every RV32M operand mix.
  assign mul_a_sx = ((op_q == MDU_MULH) || (op_q == MDU_MULHSU)) && a_q[31];
  assign mul_b_sx = (op_q == MDU_MULH) && b_q[31];
  assign mul_a    = {{32{mul_a_sx}}, a_q};
  assign mul_b    = {{32{mul_b_sx}}, b_q};
  assign mul_p    = mul_a * mul_b;

  assign signed_div = ~op_q[0];
  assign a_neg      = signed_div & a_q[31];
  assign b_neg      = signed_div & b_q[31];
  assign a_abs      = a_neg ? -a_q : a_q;
  assign b_abs      = b_neg ? -b_q : b_q;
  assign div_zero   = (b_q == 32'd0);
  assign div_ovf    = signed_div && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign special    = div_zero | div_ovf;
  assign div_start  = (state_q == ST_DIV) && div_first_q && !special && !mdu_kill_i;

  assign quo_fin = (a_neg ^ b_neg) ? -div_quo : div_quo;
  assign rem_fin = a_neg ? -div_rem : div_rem;
  assign quo_sp  = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
  assign rem_sp  = div_zero ? a_q : 32'd0;

  miriscv_mdu_div u_div (
    .clk_i       (clk_i),
    .arstn_i     (arstn_i),
    .start_i     (div_start),
    .kill_i      (mdu_kill_i),
    .dividend_i  (a_abs),
    .divisor_i   (b_abs),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    stall    = 1'b0;
    start_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mdu_req_i && !mdu_keep_i && !mdu_kill_i) begin
          stall    = 1'b1;
          start_en = 1'b1;
          state_d  = mdu_op_i[2] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        stall    = 1'b1;
        result_d = (op_q == MDU_MUL) ? mul_p[31:0] : mul_p[63:32];
        state_d  = ST_DONE;
      end
      ST_DIV: begin
        stall = 1'b1;
        if (div_first_q && special) begin
          result_d = op_q[1] ? rem_sp : quo_sp;
          state_d  = ST_DONE;
        end else if (div_done) begin
          result_d = op_q[1] ? rem_fin : quo_fin;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (mdu_kill_i) begin
      stall    = 1'b0;
      start_en = 1'b0;
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= ST_IDLE;
      op_q        <= MDU_MUL;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      div_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      div_first_q <= start_en;
      if (start_en) begin
        a_q  <= mdu_port_a_i;
        b_q  <= mdu_port_b_i;
        op_q <= mdu_op_e'(mdu_op_i);
      end
    end
  end

  assign mdu_stall_req_o = stall;
  assign mdu_result_o    = result_q;

endmodule

// File: tb/tb_miriscv_mdu.sv
// Self-checking bench for miriscv_mdu: scoreboard of expected results, stall-length checks.
module tb_miriscv_mdu;

  logic        clk_i;
  logic        arstn_i;
  logic        mdu_req_i;
  logic [31:0] mdu_port_a_i;
  logic [31:0] mdu_port_b_i;
  logic [2:0]  mdu_op_i;
  logic        mdu_kill_i;
  logic        mdu_keep_i;
  logic        mdu_stall_req_o;
  logic [31:0] mdu_result_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  miriscv_mdu dut (
    .clk_i           (clk_i),
    .arstn_i         (arstn_i),
    .mdu_req_i       (mdu_req_i),
    .mdu_port_a_i    (mdu_port_a_i),
    .mdu_port_b_i    (mdu_port_b_i),
    .mdu_op_i        (mdu_op_i),
    .mdu_kill_i      (mdu_kill_i),
    .mdu_keep_i      (mdu_keep_i),
    .mdu_stall_req_o (mdu_stall_req_o),
    .mdu_result_o    (mdu_result_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, count stall-high cycles, then compare against the scoreboard.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
    int n;
    exp_q.push_back(exp_res);
    @(negedge clk_i);
    mdu_req_i    = 1'b1;
    mdu_op_i     = op;
    mdu_port_a_i = a;
    mdu_port_b_i = b;
    #1;
    n = 0;
    while (mdu_stall_req_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk_i);
      #1;
    end
    check_eq({tag, "_stall"}, 32'(n), 32'(exp_stall));
    check_eq(tag, mdu_result_o, exp_q.pop_front());
    mdu_req_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] ra, rb, prev;
    logic [63:0] p;

    arstn_i      = 1'b0;
    mdu_req_i    = 1'b0;
    mdu_port_a_i = '0;
    mdu_port_b_i = '0;
    mdu_op_i     = '0;
    mdu_kill_i   = 1'b0;
    mdu_keep_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check_eq("rst_stall", 32'(mdu_stall_req_o), 32'd0);
    check_eq("rst_result", mdu_result_o, 32'd0);
    @(negedge clk_i);
    arstn_i = 1'b1;

    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    run_op("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu", 3'd5, 32'd100,       32'd7, 32'd14,        33);
    run_op("remu", 3'd7, 32'd100,       32'd7, 32'd2,         33);

    run_op("divu_z", 3'd5, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 2);
    run_op("remu_z", 3'd7, 32'h1234_5678, 32'd0,         32'h1234_5678, 2);
    run_op("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);

    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      p  = {32'd0, ra} * {32'd0, rb};
      run_op("rnd_mulhu", 3'd3, ra, rb, p[63:32], 2);
    end

    // Kill a divide part-way through its iterations.
    prev = p[63:32];
    @(negedge clk_i);
    mdu_req_i    = 1'b1;
    mdu_op_i     = 3'd5;
    mdu_port_a_i = 32'd1000;
    mdu_port_b_i = 32'd3;
    repeat (10) @(negedge clk_i);
    #1;
    check_eq("kill_pre_stall", 32'(mdu_stall_req_o), 32'd1);
    mdu_kill_i = 1'b1;
    #1;
    check_eq("kill_stall", 32'(mdu_stall_req_o), 32'd0);
    @(negedge clk_i);
    mdu_kill_i = 1'b0;
    mdu_req_i  = 1'b0;
    #1;
    check_eq("kill_idle_stall", 32'(mdu_stall_req_o), 32'd0);
    check_eq("kill_result", mdu_result_o, prev);
    run_op("mul_after_kill", 3'd0, 32'd3, 32'd4, 32'd12, 2);

    // keep with req: no restart, result held.
    mdu_req_i    = 1'b1;
    mdu_keep_i   = 1'b1;
    mdu_op_i     = 3'd4;
    mdu_port_a_i = 32'd50;
    mdu_port_b_i = 32'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("keep_stall", 32'(mdu_stall_req_o), 32'd0);
      check_eq("keep_result", mdu_result_o, 32'd12);
      @(negedge clk_i);
    end
    mdu_req_i  = 1'b0;
    mdu_keep_i = 1'b0;
    @(negedge clk_i);

    // Asynchronous reset in the middle of a divide.
    mdu_req_i    = 1'b1;
    mdu_op_i     = 3'd5;
    mdu_port_a_i = 32'd100;
    mdu_port_b_i = 32'd7;
    repeat (5) @(negedge clk_i);
    #2;
    arstn_i   = 1'b0;
    mdu_req_i = 1'b0;
    #1;
    check_eq("arst_stall", 32'(mdu_stall_req_o), 32'd0);
    check_eq("arst_result", mdu_result_o, 32'd0);
    @(negedge clk_i);
    arstn_i = 1'b1;
    run_op("divu_after_rst", 3'd5, 32'd100, 32'd7, 32'd14, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
